fft_stage_sched: RTL
====================

# fft_stage_sched

Radix-2 decimation-in-frequency stage scheduler for the in-place sfp FFT datapath under `top_control`. On `fft_start` it latches `fft_size`. For each of log2(N) stages it issues N/2 butterfly operand addresses and twiddle indices, one per cycle. It delays the write-back addresses to match the butterfly pipeline, inserts drain gaps between stages so in-place read-after-write hazards cannot occur, and pulses `fft_done` when the final write-back has been issued.

## Interface
Parameters:
- `MAX_LOG2N`, default 5: log2 of the largest supported FFT; address width.
- `BF_LATENCY`, default 4: butterfly pipeline depth in cycles from issue to write-back; must be ≥1.

Ports:
- `clk`  in  1: single clock.
- `rst`  in  1: synchronous, active-high reset.
- `fft_start`  in  1: start request, sampled only in IDLE.
- `fft_size`  in  11: point count N, latched on accepted start.
- `busy`  out  1: run in progress.
- `fft_done`  out  1: one-cycle completion pulse.
- `size_err`  out  1: one-cycle pulse when a start carries an illegal size.
- `bf_valid`  out  1: butterfly issue strobe.
- `bf_addr_a`, `bf_addr_b`  out  MAX_LOG2N: operand addresses (top/bottom).
- `tw_idx`  out  MAX_LOG2N-1: index into the W_MAXN^k twiddle table of 2^(MAX_LOG2N-1) entries.
- `bf_stage`  out  3: current stage number.
- `wb_valid`  out  1: write-back strobe, equal to `bf_valid` delayed BF_LATENCY cycles.
- `wb_addr_a`, `wb_addr_b`  out  MAX_LOG2N: `bf_addr_a`/`bf_addr_b` delayed BF_LATENCY cycles.

## Operation
- Legal N: powers of two, 2 ≤ N ≤ 2^MAX_LOG2N. L = log2(N).
- FSM states:
  - IDLE: on `fft_start`, a legal size goes to ISSUE. An illegal size pulses `size_err` for one cycle and stays in IDLE.
  - ISSUE: issues one butterfly per cycle, N/2 per stage. After the last butterfly of the stage, goes to DRAIN.
  - DRAIN: lasts exactly BF_LATENCY cycles. Then goes to ISSUE with stage+1, or to DONE if the finished stage was L-1.
  - DONE: lasts one cycle, then IDLE.
- Butterfly k (0..N/2-1) of stage s:
  - h = N >> (s+1)
  - g = k / h, j = k mod h
  - `bf_addr_a` = 2·g·h + j, `bf_addr_b` = `bf_addr_a` + h
  - `tw_idx` = j << (s + MAX_LOG2N − L)
- Computation uses shifts and masks only; no dividers. Carry k and j as counters.
- `fft_start` is ignored while busy. `fft_size` changes after the start is accepted have no effect.
- Write-back delay line: BF_LATENCY registers carrying {valid, addr_a, addr_b}. It shifts every cycle in every state.

## Timing
- Reset values: all outputs 0, FSM in IDLE, delay line cleared.
- Reset mid-run: on the next edge the block returns to IDLE with all outputs 0. No `fft_done` is produced, and in-flight `wb_valid` entries are discarded.
- Cycle 0 is the edge on which the start is accepted. `busy`=1 from cycle 1 through the DONE cycle inclusive.
- Stage s issues in cycles 1 + s·(N/2 + BF_LATENCY) through s·(N/2 + BF_LATENCY) + N/2, with `bf_valid`=1 and no bubbles.
- `bf_valid`=0 during DRAIN. The next stage's first read occurs one cycle after the previous stage's last `wb_valid`.
- `fft_done` is high in cycle L·(N/2 + BF_LATENCY) + 1, the cycle after the final `wb_valid`. `busy` drops the following cycle.
- A new start is accepted the cycle after DONE. Back-to-back runs are supported.
- `size_err` is high in cycle 1 and `busy` stays 0.

## Test plan
- N=4, BF_LATENCY=4 -> stage 0:
  - cycle 1: (a,b,tw)=(0,2,0)
  - cycle 2: (1,3,8)
  - cycles 3–6: `bf_valid`=0
  - stage 1, cycle 7: (0,1,0); cycle 8: (2,3,0)
  - `wb_valid` in cycles 5, 6, 11, 12
  - `fft_done` in cycle 13 only
- N=32 -> 5 stages × 16 issues. Stage s first issue at cycle 1+20s; `fft_done` at cycle 101. A scoreboard checks every (a,b,tw) against the formula, and checks that each address is written exactly once per stage.
- N=2 -> single issue (0,1,0) at cycle 1, `wb_valid` at 5, `fft_done` at 6.
- `fft_size`=24, then 0, then 64 -> `size_err` pulses at cycle 1 each time; `busy`, `bf_valid` and `fft_done` stay 0.
- N=32 with `fft_start` re-pulsed at cycle 40 and `fft_size` changed to 8 at cycle 40 -> no effect; `fft_done` still at 101. A start at cycle 102 launches a new run.
- N=16 with `rst` asserted at cycle 30 -> all outputs 0 from cycle 31. No `wb_valid` after cycle 31, no `fft_done`. A start afterwards runs normally to completion.

Source files
------------

// File: rtl/fft_stage_sched.sv
// Radix-2 DIF stage scheduler: issues butterfly operand addresses and twiddle
// indices stage by stage, with a matched write-back delay line and drain gaps.
module fft_stage_sched #(
  parameter int MAX_LOG2N  = 5,
  parameter int BF_LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fft_start,
  input  logic [10:0]          fft_size,
  output logic                 busy,
  output logic                 fft_done,
  output logic                 size_err,
  output logic                 bf_valid,
  output logic [MAX_LOG2N-1:0] bf_addr_a,
  output logic [MAX_LOG2N-1:0] bf_addr_b,
  output logic [MAX_LOG2N-2:0] tw_idx,
  output logic [2:0]           bf_stage,
  output logic                 wb_valid,
  output logic [MAX_LOG2N-1:0] wb_addr_a,
  output logic [MAX_LOG2N-1:0] wb_addr_b
);

  localparam int AW = MAX_LOG2N;
  localparam int TW = MAX_LOG2N - 1;
  localparam int DW = $clog2(BF_LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      log2n_q, log2n_d;
  logic [3:0]      stage_q, stage_d;
  logic [3:0]      shift_q, shift_d;
  logic [AW-1:0]   n_half_q, n_half_d;
  logic [AW-1:0]   h_q, h_d;
  logic [AW-1:0]   k_q, k_d;
  logic [AW-1:0]   j_q, j_d;
  logic [AW-1:0]   base_q, base_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic            err_q, err_d;

  logic            issue;
  logic            size_ok;
  logic [3:0]      size_log2;

  logic            busy_q, done_q, size_err_q, bf_valid_q;
  logic [AW-1:0]   bf_addr_a_q, bf_addr_b_q;
  logic [TW-1:0]   tw_idx_q;
  logic [3:0]      bf_stage_q;

  logic [BF_LATENCY-1:0]         wbv_q;
  logic [BF_LATENCY-1:0][AW-1:0] wba_q;
  logic [BF_LATENCY-1:0][AW-1:0] wbb_q;

  always_comb begin
    size_log2 = '0;
    for (int i = 0; i < 11; i++) begin
      if (fft_size[i]) size_log2 = 4'(i);
    end
    size_ok = (fft_size >= 11'd2) && (fft_size <= (11'd1 << MAX_LOG2N)) &&
              ((fft_size & (fft_size - 11'd1)) == 11'd0);
  end

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    log2n_d  = log2n_q;
    stage_d  = stage_q;
    shift_d  = shift_q;
    n_half_d = n_half_q;
    h_d      = h_q;
    k_d      = k_q;
    j_d      = j_q;
    base_d   = base_q;
    drain_d  = drain_q;
    err_d    = 1'b0;
    issue    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fft_start) begin
          if (size_ok) begin
            state_d  = S_ISSUE;
            log2n_d  = size_log2;
            n_half_d = AW'(fft_size >> 1);
            h_d      = AW'(fft_size >> 1);
            stage_d  = '0;
            shift_d  = 4'(MAX_LOG2N) - size_log2;
            k_d      = '0;
            j_d      = '0;
            base_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        issue = 1'b1;
        if (k_q == n_half_q - 1'b1) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else begin
          k_d = k_q + 1'b1;
          // j wraps at h; each wrap moves to the next butterfly group of width 2h.
          if (j_q == h_q - 1'b1) begin
            j_d    = '0;
            base_d = base_q + (h_q << 1);
          end else begin
            j_d = j_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == DW'(BF_LATENCY - 1)) begin
          if (stage_q == log2n_q - 4'd1) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
            stage_d = stage_q + 4'd1;
            shift_d = shift_q + 4'd1;
            h_d     = h_q >> 1;
            k_d     = '0;
            j_d     = '0;
            base_d  = '0;
          end
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      log2n_q     <= '0;
      stage_q     <= '0;
      shift_q     <= '0;
      n_half_q    <= '0;
      h_q         <= '0;
      k_q         <= '0;
      j_q         <= '0;
      base_q      <= '0;
      drain_q     <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      size_err_q  <= 1'b0;
      bf_valid_q  <= 1'b0;
      bf_addr_a_q <= '0;
      bf_addr_b_q <= '0;
      tw_idx_q    <= '0;
      bf_stage_q  <= '0;
      // NOTE: the delay line is cleared too, so in-flight write-backs die on reset.
      wbv_q       <= '0;
      wba_q       <= '0;
      wbb_q       <= '0;
    end else begin
      state_q     <= state_d;
      log2n_q     <= log2n_d;
      stage_q     <= stage_d;
      shift_q     <= shift_d;
      n_half_q    <= n_half_d;
      h_q         <= h_d;
      k_q         <= k_d;
      j_q         <= j_d;
      base_q      <= base_d;
      drain_q     <= drain_d;
      err_q       <= err_d;
      busy_q      <= (state_q != S_IDLE);
      done_q      <= (state_q == S_DONE);
      size_err_q  <= err_q;
      bf_valid_q  <= issue;
      bf_addr_a_q <= issue ? base_q + j_q : '0;
      bf_addr_b_q <= issue ? base_q + j_q + h_q : '0;
      tw_idx_q    <= issue ? TW'(j_q << shift_q) : '0;
      bf_stage_q  <= (state_q == S_IDLE) ? 4'd0 : stage_q;
      wbv_q[0]    <= bf_valid_q;
      wba_q[0]    <= bf_addr_a_q;
      wbb_q[0]    <= bf_addr_b_q;
      for (int i = 1; i < BF_LATENCY; i++) begin
        wbv_q[i] <= wbv_q[i-1];
        wba_q[i] <= wba_q[i-1];
        wbb_q[i] <= wbb_q[i-1];
      end
    end
  end

  assign busy      = busy_q;
  assign fft_done  = done_q;
  assign size_err  = size_err_q;
  assign bf_valid  = bf_valid_q;
  assign bf_addr_a = bf_addr_a_q;
  assign bf_addr_b = bf_addr_b_q;
  assign tw_idx    = tw_idx_q;
  assign bf_stage  = 3'(bf_stage_q);
  assign wb_valid  = wbv_q[BF_LATENCY-1];
  assign wb_addr_a = wba_q[BF_LATENCY-1];
  assign wb_addr_b = wbb_q[BF_LATENCY-1];

endmodule
